// File: rtl/wfm_packetizer_pkg.sv
// Shared definitions for the waveform packetizer: markers, state encoding,
// word field positions, the output-stage payload and word builders.
package wfm_packetizer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SAMP_W = 14;
    localparam int unsigned TIME_W = 40;
    localparam int unsigned EVT_W  = 24;
    localparam int unsigned CSUM_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [7:0] HDR_MARK_DEF = 8'hA5;
    localparam logic [7:0] TRL_MARK_DEF = 8'h5A;
    localparam logic [7:0] H1_TAG       = 8'hB1;

    // Field positions inside the 32-bit stream words
    localparam int unsigned MARK_LSB  = 24;
    localparam int unsigned TRUNC_BIT = 23;
    localparam int unsigned CH2_LSB   = 16;
    localparam int unsigned CH1_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H0   = 3'd1,
        ST_H1   = 3'd2,
        ST_H2   = 3'd3,
        ST_H3   = 3'd4,
        ST_SAMP = 3'd5,
        ST_TRL  = 3'd6
    } state_e;

    // Payload carried by the output register: framing flags plus data word
    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [WORD_W-1:0] data;
    } st_word_t;

    // Sample pair word: {2'b00, ch2, 2'b00, ch1}
    function automatic logic [WORD_W-1:0] samp_word(input logic [SAMP_W-1:0] s1,
                                                    input logic [SAMP_W-1:0] s2);
        return {2'b00, s2, 2'b00, s1};
    endfunction

    // Trailer word: {marker, trunc, 7'b0, checksum}
    function automatic logic [WORD_W-1:0] trl_word(input logic [7:0]        mark,
                                                   input logic              trunc,
                                                   input logic [CSUM_W-1:0] csum);
        return {mark, trunc, 7'b0, csum};
    endfunction

endpackage

// File: rtl/wfm_packetizer_st_out_reg.sv
// st_out_reg: single valid/ready output register (data + sop/eop) that holds
// its word while stalled and reloads in the same cycle the sink accepts.
//   clk, rst_n   : clock, async active-low reset
//   push_i       : a new word is offered (taken only when can_load_c)
//   word_i       : offered payload
//   ready_i      : sink ready
//   valid_o      : registered word valid
//   word_o       : registered payload
//   can_load_c   : register is empty or being drained this cycle
module st_out_reg
    import wfm_packetizer_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  st_word_t word_i,
    input  logic     ready_i,
    output logic     valid_o,
    output st_word_t word_o,
    output logic     can_load_c
);

    logic     valid_q, valid_d;
    st_word_t word_q, word_d;

    assign can_load_c = ~valid_q | ready_i;

    // Next-state: load on bypass slot, otherwise hold
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (can_load_c) begin
            valid_d = push_i;
            if (push_i) begin
                word_d = word_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;

endmodule

// File: rtl/wfm_packetizer.sv
// wfm_packetizer: on each accepted trigger, frames NSAMP paired ADC samples
// with a 4-word header and a checksum trailer on a 32-bit valid/ready stream.
//   clk, rst_n          : system clock, async active-low reset
//   enable, trig_start  : trigger arm and one-cycle trigger pulse
//   in_time             : 40-bit time, latched on accepted trigger
//   fifo{1,2}_q/_empty  : show-ahead sample FIFOs; fifo_rdreq pops both
//   out_*               : packet stream (sop on header 0, eop on trailer)
//   busy                : not idle
//   evt_cnt/drop_cnt/trunc_cnt : completed, dropped-trigger, truncated counts
module wfm_packetizer
    import wfm_packetizer_pkg::*;
#(
    parameter int unsigned NSAMP    = 1024,
    parameter int unsigned TIMEOUT  = 4096,
    parameter logic [7:0]  HDR_MARK = HDR_MARK_DEF,
    parameter logic [7:0]  TRL_MARK = TRL_MARK_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              trig_start,
    input  logic [TIME_W-1:0] in_time,
    input  logic [SAMP_W-1:0] fifo1_q,
    input  logic              fifo1_empty,
    input  logic [SAMP_W-1:0] fifo2_q,
    input  logic              fifo2_empty,
    output logic              fifo_rdreq,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic [EVT_W-1:0]  evt_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  trunc_cnt
);

    localparam int unsigned SCNT_W = $clog2(NSAMP + 1);
    localparam int unsigned TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [EVT_W-1:0]    evt_num_q, evt_num_d;
    logic [EVT_W-1:0]    evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]    trunc_cnt_q, trunc_cnt_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic                trunc_q, trunc_d;
    logic                trl_sent_q, trl_sent_d;
    logic                busy_q, busy_d;

    logic                trig_ok_c;
    logic                any_empty_c;
    logic                pop_c;
    logic                push_c;
    logic                can_load_c;
    logic                oreg_valid;
    st_word_t            push_word_c;
    st_word_t            oreg_word;

    assign trig_ok_c   = trig_start & enable;
    assign any_empty_c = fifo1_empty | fifo2_empty;

    // Pop only in SAMP, when both FIFOs have data and the output slot frees up
    assign pop_c = (state_q == ST_SAMP) & ~any_empty_c & can_load_c
                 & (scnt_q < SCNT_W'(NSAMP));

    // Next-state and word-offer logic
    always_comb begin
        state_d     = state_q;
        evt_num_d   = evt_num_q;
        evt_cnt_d   = evt_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        time_d      = time_q;
        scnt_d      = scnt_q;
        tcnt_d      = tcnt_q;
        csum_d      = csum_q;
        trunc_d     = trunc_q;
        trl_sent_d  = trl_sent_q;
        push_c      = 1'b0;
        push_word_c = '0;

        // Any armed trigger outside IDLE is dropped, including the trailer-accept cycle
        if ((state_q != ST_IDLE) && trig_ok_c && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_ok_c) begin
                    time_d     = in_time;
                    scnt_d     = '0;
                    tcnt_d     = '0;
                    csum_d     = '0;
                    trunc_d    = 1'b0;
                    trl_sent_d = 1'b0;
                    state_d    = ST_H0;
                end
            end
            ST_H0: begin
                if (can_load_c) begin
                    push_c           = 1'b1;
                    push_word_c.sop  = 1'b1;
                    push_word_c.data = {HDR_MARK, evt_num_q};
                    state_d          = ST_H1;
                end
            end
            ST_H1: begin
                if (can_load_c) begin
                    push_c           = 1'b1;
                    push_word_c.data = {H1_TAG, 8'h00, 16'(NSAMP)};
                    state_d          = ST_H2;
                end
            end
            ST_H2: begin
                if (can_load_c) begin
                    push_c           = 1'b1;
                    push_word_c.data = {24'h0, time_q[TIME_W-1:32]};
                    state_d          = ST_H3;
                end
            end
            ST_H3: begin
                if (can_load_c) begin
                    push_c           = 1'b1;
                    push_word_c.data = time_q[31:0];
                    state_d          = ST_SAMP;
                end
            end
            ST_SAMP: begin
                if (pop_c) begin
                    push_c           = 1'b1;
                    push_word_c.data = samp_word(fifo1_q, fifo2_q);
                    csum_d           = csum_q + CSUM_W'(fifo1_q) + CSUM_W'(fifo2_q);
                    scnt_d           = scnt_q + 1'b1;
                    tcnt_d           = '0;
                    if (scnt_q == SCNT_W'(NSAMP - 1)) begin
                        state_d = ST_TRL;
                    end
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    trunc_d = 1'b1;
                    state_d = ST_TRL;
                end else if (any_empty_c) begin
                    // Only starvation counts; pure backpressure stalls do not
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_TRL: begin
                if (!trl_sent_q) begin
                    if (can_load_c) begin
                        push_c           = 1'b1;
                        push_word_c.eop  = 1'b1;
                        push_word_c.data = trl_word(TRL_MARK, trunc_q, csum_q);
                        trl_sent_d       = 1'b1;
                    end
                end else if (oreg_valid && out_ready) begin
                    // Trailer is the only word left in the register here
                    evt_num_d  = evt_num_q + 1'b1;
                    evt_cnt_d  = evt_cnt_q + 1'b1;
                    trl_sent_d = 1'b0;
                    if (trunc_q && (trunc_cnt_q != '1)) begin
                        trunc_cnt_d = trunc_cnt_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            evt_num_q   <= '0;
            evt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
            time_q      <= '0;
            scnt_q      <= '0;
            tcnt_q      <= '0;
            csum_q      <= '0;
            trunc_q     <= 1'b0;
            trl_sent_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            evt_num_q   <= evt_num_d;
            evt_cnt_q   <= evt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
            time_q      <= time_d;
            scnt_q      <= scnt_d;
            tcnt_q      <= tcnt_d;
            csum_q      <= csum_d;
            trunc_q     <= trunc_d;
            trl_sent_q  <= trl_sent_d;
            busy_q      <= busy_d;
        end
    end

    st_out_reg u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_c),
        .word_i     (push_word_c),
        .ready_i    (out_ready),
        .valid_o    (oreg_valid),
        .word_o     (oreg_word),
        .can_load_c (can_load_c)
    );

    assign fifo_rdreq = pop_c;
    assign out_valid  = oreg_valid;
    assign out_data   = oreg_word.data;
    assign out_sop    = oreg_word.sop;
    assign out_eop    = oreg_word.eop;
    assign busy       = busy_q;
    assign evt_cnt    = evt_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign trunc_cnt  = trunc_cnt_q;

endmodule

// File: tb/tb_wfm_packetizer.sv
// Directed bench for wfm_packetizer (NSAMP=8, TIMEOUT=16) with a small
// show-ahead FIFO model and a stream capture monitor.
module tb_wfm_packetizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        trig_start = 1'b0;
    logic [39:0] in_time = '0;
    logic [13:0] fifo1_q, fifo2_q;
    logic        fifo1_empty, fifo2_empty;
    logic        fifo_rdreq;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop, out_eop, busy;
    logic [23:0] evt_cnt;
    logic [15:0] drop_cnt, trunc_cnt;

    always #5 clk = ~clk;

    wfm_packetizer #(.NSAMP(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trig_start(trig_start),
        .in_time(in_time), .fifo1_q(fifo1_q), .fifo1_empty(fifo1_empty),
        .fifo2_q(fifo2_q), .fifo2_empty(fifo2_empty), .fifo_rdreq(fifo_rdreq),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .evt_cnt(evt_cnt),
        .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
    );

    // FIFO model: main thread writes data/wr pointers, pop process owns rd pointers
    logic [13:0] f1 [64];
    logic [13:0] f2 [64];
    logic [5:0]  wr1 = '0, wr2 = '0, rd1 = '0, rd2 = '0;
    assign fifo1_q     = f1[rd1];
    assign fifo2_q     = f2[rd2];
    assign fifo1_empty = (rd1 == wr1);
    assign fifo2_empty = (rd2 == wr2);

    int          cyc = 0;
    int          rel;
    logic        pop_pend = 1'b0;
    logic        flush_req = 1'b0;
    logic        ready_mode = 1'b0;
    int          t2_start = 0;

    logic [33:0] cap [$];
    int          eop_cnt = 0;
    int          last_pop_cyc = 0;
    int          trl_cyc = 0;
    int          stall_viol = 0;
    int          idle_pop = 0;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cap_base;
    int          eop_base;
    logic [33:0] exp_q [$];

    // Pop and ready generation, just after the active edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (flush_req) begin
            rd1 = wr1;
            rd2 = wr2;
        end else if (pop_pend) begin
            rd1 = rd1 + 6'd1;
            rd2 = rd2 + 6'd1;
        end
        rel = cyc - t2_start;
        if (!ready_mode) out_ready = 1'b1;
        else if (rel >= 20 && rel < 25) out_ready = 1'b0;
        else out_ready = (rel % 2 == 0);
    end

    // Stream monitor on the falling edge
    always @(negedge clk) begin
        pop_pend = fifo_rdreq;
        if (fifo_rdreq) last_pop_cyc = cyc;
        if (fifo_rdreq && out_valid && !out_ready) stall_viol = stall_viol + 1;
        if (fifo_rdreq && !busy) idle_pop = idle_pop + 1;
        if (out_valid && out_ready) begin
            cap.push_back({out_sop, out_eop, out_data});
            if (out_eop) begin
                eop_cnt = eop_cnt + 1;
                trl_cyc = cyc;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load(input int n1, input int n2);
        for (int i = 0; i < n1; i++) begin
            f1[wr1] = 14'(i);
            wr1 = wr1 + 6'd1;
        end
        for (int i = 0; i < n2; i++) begin
            f2[wr2] = 14'(100 + i);
            wr2 = wr2 + 6'd1;
        end
    endtask

    task automatic flush();
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
    endtask

    task automatic mark();
        cap_base = cap.size();
        eop_base = eop_cnt;
    endtask

    task automatic trig(input logic [39:0] t);
        trig_start = 1'b1;
        in_time    = t;
        step(1);
        trig_start = 1'b0;
    endtask

    task automatic wait_pkt(input string tag);
        int i;
        i = 0;
        while (eop_cnt == eop_base && i < 300) begin
            step(1);
            i++;
        end
        check_val({tag, "_done"}, 64'(eop_cnt > eop_base), 64'd1);
    endtask

    // Expected packet: ramp ch1=k, ch2=100+k for k < n
    task automatic build_exp(input logic [23:0] evt, input logic [39:0] t,
                             input int n, input logic trunc);
        logic [15:0] cs;
        cs = '0;
        exp_q.delete();
        exp_q.push_back({2'b10, 8'hA5, evt});
        exp_q.push_back({2'b00, 32'hB100_0008});
        exp_q.push_back({2'b00, 24'h0, t[39:32]});
        exp_q.push_back({2'b00, t[31:0]});
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({2'b00, 2'b00, 14'(100 + k), 2'b00, 14'(k)});
            cs = cs + 16'(k) + 16'(100 + k);
        end
        exp_q.push_back({2'b01, 8'h5A, trunc, 7'b0, cs});
    endtask

    task automatic check_pkt(input string tag);
        check_val({tag, "_len"}, 64'(cap.size() - cap_base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check_val($sformatf("%s_w%0d", tag, i), 64'(cap[cap_base + i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        step(2);
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_data", 64'({out_sop, out_eop, out_data}), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_cnts", 64'({evt_cnt, drop_cnt, trunc_cnt}), 64'd0);
        rst_n = 1'b1;
        step(2);

        // T1: basic packet, sink always ready
        load(8, 8);
        mark();
        trig(40'h12_3456_789A);
        wait_pkt("t1");
        build_exp(24'd0, 40'h12_3456_789A, 8, 1'b0);
        check_pkt("t1");
        check_val("t1_h0", 64'(cap[cap_base][31:0]), 64'hA500_0000);
        check_val("t1_s0", 64'(cap[cap_base + 4][31:0]), 64'h0064_0000);
        check_val("t1_trl", 64'(cap[cap_base + 12][31:0]), 64'h5A00_0358);
        step(2);
        check_val("t1_evt", 64'(evt_cnt), 64'd1);
        check_val("t1_busy", 64'(busy), 64'd0);

        // T2: toggling ready with a 5-cycle low window
        load(8, 8);
        mark();
        t2_start   = cyc;
        ready_mode = 1'b1;
        trig(40'h12_3456_789A);
        wait_pkt("t2");
        ready_mode = 1'b0;
        build_exp(24'd1, 40'h12_3456_789A, 8, 1'b0);
        check_pkt("t2");
        check_val("t2_stall_pop", 64'(stall_viol), 64'd0);
        step(2);

        // T3: fifo2 starves after 3 samples
        load(8, 3);
        mark();
        trig(40'h00_0000_0042);
        wait_pkt("t3");
        build_exp(24'd2, 40'h00_0000_0042, 3, 1'b1);
        check_pkt("t3");
        check_val("t3_tmo", 64'((trl_cyc - last_pop_cyc) >= 16 && (trl_cyc - last_pop_cyc) <= 19), 64'd1);
        step(2);
        check_val("t3_trunc_cnt", 64'(trunc_cnt), 64'd1);
        flush();

        // T4: triggers while busy are dropped
        load(8, 8);
        mark();
        trig(40'h00_0000_0100);
        for (int i = 0; i < 3; i++) begin
            step(2);
            trig(40'h00_0000_0999);
        end
        wait_pkt("t4");
        step(4);
        build_exp(24'd3, 40'h00_0000_0100, 8, 1'b0);
        check_pkt("t4");
        check_val("t4_drop", 64'(drop_cnt), 64'd3);
        check_val("t4_one_pkt", 64'(eop_cnt - eop_base), 64'd1);
        load(8, 8);
        mark();
        trig(40'h00_0000_0200);
        wait_pkt("t4b");
        check_val("t4b_h0", 64'(cap[cap_base]), 64'({2'b10, 32'hA500_0004}));
        step(2);
        check_val("t4b_evt", 64'(evt_cnt), 64'd5);
        check_val("t4b_trunc", 64'(trunc_cnt), 64'd1);

        // T5: disabled triggers do nothing
        enable = 1'b0;
        load(8, 8);
        mark();
        for (int i = 0; i < 3; i++) begin
            trig(40'h00_0000_0300);
            step(3);
        end
        step(20);
        check_val("t5_nowords", 64'(cap.size() - cap_base), 64'd0);
        check_val("t5_busy", 64'(busy), 64'd0);
        check_val("t5_drop", 64'(drop_cnt), 64'd3);
        flush();
        enable = 1'b1;

        // T6: reset in the middle of SAMP
        load(8, 8);
        mark();
        trig(40'h00_0000_0400);
        step(7);
        check_val("t6_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        step(1);
        check_val("t6_rst_valid", 64'(out_valid), 64'd0);
        check_val("t6_rst_busy", 64'(busy), 64'd0);
        check_val("t6_rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check_val("t6_rst_cnts", 64'({evt_cnt, drop_cnt, trunc_cnt}), 64'd0);
        rst_n = 1'b1;
        flush();
        step(1);
        load(8, 8);
        mark();
        trig(40'h12_3456_789A);
        wait_pkt("t6");
        build_exp(24'd0, 40'h12_3456_789A, 8, 1'b0);
        check_pkt("t6");
        step(2);
        check_val("t6_evt", 64'(evt_cnt), 64'd1);

        check_val("idle_pop", 64'(idle_pop), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
